// File: rtl/scurve_pkg.sv
// ---------------------------------------------------------------------------
// scurve_pkg
// Shared definitions for the S-curve injection sequencer. It holds the
// sequencer state encoding, the number of words emitted per threshold point
// and the default DAC/counter widths.
// ---------------------------------------------------------------------------
package scurve_pkg;

    localparam int DEFAULT_DAC_WIDTH = 10;
    localparam int DEFAULT_CNT_WIDTH = 16;

    // Each threshold point produces the DAC code, the pulse count and the
    // trigger count, in that order.
    localparam int WORDS_PER_POINT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_CLEAR    = 4'd3,
        ST_RUN      = 4'd4,
        ST_WR_DAC   = 4'd5,
        ST_WR_PULSE = 4'd6,
        ST_WR_TRIG  = 4'd7,
        ST_NEXT     = 4'd8,
        ST_FINISH   = 4'd9
    } seq_state_t;

endpackage

// File: rtl/inject_pulse_gen.sv
// ---------------------------------------------------------------------------
// inject_pulse_gen
// Generates the CLK_EXT charge-injection clock while the sequencer is in RUN.
// CLK_EXT is high for High_eff cycles and then low for the remainder of
// Period_eff, with High_eff = max(Pulse_High,1) and
// Period_eff = max(Pulse_Period, High_eff+1).
//
// Ports:
//   Clk, reset_n   system clock, asynchronous active-low reset
//   Run_Start      one-cycle request: the next cycle is the first RUN cycle;
//                  CLK_EXT goes high and the phase counter restarts at 0
//   Run_Stop       one-cycle request: stop and hold CLK_EXT low
//                  (takes priority over Run_Start)
//   Pulse_Period   CLK_EXT period in Clk cycles (raw, clamped here)
//   Pulse_High     CLK_EXT high time in Clk cycles (raw, clamped here)
//   CLK_EXT        registered injection clock
// ---------------------------------------------------------------------------
module inject_pulse_gen #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 Run_Start,
    input  logic                 Run_Stop,
    input  logic [CNT_WIDTH-1:0] Pulse_Period,
    input  logic [CNT_WIDTH-1:0] Pulse_High,
    output logic                 CLK_EXT
);

    // One extra bit so that High_eff+1 never wraps when Pulse_High is all ones.
    localparam int PW = CNT_WIDTH + 1;

    logic [PW-1:0] high_eff;
    logic [PW-1:0] period_eff;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic          running;

    always_comb begin
        high_eff   = (Pulse_High == '0) ? PW'(1) : {1'b0, Pulse_High};
        period_eff = ({1'b0, Pulse_Period} > high_eff) ? {1'b0, Pulse_Period}
                                                       : high_eff + PW'(1);
        phase_next = (phase + PW'(1) >= period_eff) ? '0 : phase + PW'(1);
    end

    // CLK_EXT is computed from the phase it will have in the coming cycle so
    // that the output stays registered yet rises in the very first RUN cycle.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            phase   <= '0;
            CLK_EXT <= 1'b0;
        end else if (Run_Stop) begin
            running <= 1'b0;
            phase   <= '0;
            CLK_EXT <= 1'b0;
        end else if (Run_Start) begin
            running <= 1'b1;
            phase   <= '0;
            CLK_EXT <= 1'b1;
        end else if (running) begin
            phase   <= phase_next;
            CLK_EXT <= (phase_next < high_eff);
        end
    end

endmodule

// File: rtl/scurve_inject_sequencer.sv
// ---------------------------------------------------------------------------
// scurve_inject_sequencer
// Initiator side of the SDHCAL S-curve measurement. For every threshold
// point of a DAC sweep it loads the DAC, waits for settling, clears the
// S-curve counter, runs the injection clock until the counter reports
// CPT_DONE, and then streams {DAC code, pulse count, trigger count} over a
// valid/ready interface towards the USB FIFO.
//
// Ports:
//   Clk, reset_n          system clock, asynchronous active-low reset
//   Start, Abort          one-cycle control pulses (Abort wins)
//   DAC_Start/Stop/Step   sweep range and step, sampled on accepted Start
//   Pulse_Period/High     injection clock shape, sampled on accepted Start
//   Settle_Time           wait after each DAC load, sampled on accepted Start
//   DAC_Code, DAC_Load    threshold code and its one-cycle update strobe
//   Counter_Clr_n         one-cycle low clear pulse for the S-curve counter
//   Test_Start            counter enable level, high during RUN
//   CLK_EXT               injection clock
//   CPT_DONE/PULSE/TRIGGER  counter completion pulse and results
//   Data_Out/Valid/Ready  output word stream
//   Busy, Sweep_Done      sweep in progress / normal completion pulse
// ---------------------------------------------------------------------------
module scurve_inject_sequencer
    import scurve_pkg::*;
#(
    parameter int DAC_WIDTH = DEFAULT_DAC_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic [DAC_WIDTH-1:0] DAC_Start,
    input  logic [DAC_WIDTH-1:0] DAC_Stop,
    input  logic [DAC_WIDTH-1:0] DAC_Step,
    input  logic [CNT_WIDTH-1:0] Pulse_Period,
    input  logic [CNT_WIDTH-1:0] Pulse_High,
    input  logic [CNT_WIDTH-1:0] Settle_Time,
    output logic [DAC_WIDTH-1:0] DAC_Code,
    output logic                 DAC_Load,
    output logic                 Counter_Clr_n,
    output logic                 Test_Start,
    output logic                 CLK_EXT,
    input  logic                 CPT_DONE,
    input  logic [CNT_WIDTH-1:0] CPT_PULSE,
    input  logic [CNT_WIDTH-1:0] CPT_TRIGGER,
    output logic [CNT_WIDTH-1:0] Data_Out,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic                 Busy,
    output logic                 Sweep_Done
);

    seq_state_t           state;

    logic [DAC_WIDTH-1:0] dac_stop_r;
    logic [DAC_WIDTH-1:0] dac_step_r;
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] high_r;
    logic [CNT_WIDTH-1:0] settle_r;
    logic [CNT_WIDTH-1:0] settle_cnt;
    logic [CNT_WIDTH-1:0] snap_pulse;
    logic [CNT_WIDTH-1:0] snap_trig;

    logic [DAC_WIDTH:0]   next_code;
    logic [CNT_WIDTH-1:0] word_sel;
    seq_state_t           word_next_state;
    logic                 gen_start;
    logic                 gen_stop;

    // The step is added one bit wider than the code so that a sweep ending
    // near full scale terminates instead of wrapping back to zero.
    assign next_code = {1'b0, DAC_Code} + {1'b0, dac_step_r};

    // Word presented in the current write state and the state that follows
    // once that word has been accepted by the sink.
    always_comb begin
        word_sel        = snap_trig;
        word_next_state = ST_NEXT;
        case (state)
            ST_WR_DAC: begin
                word_sel        = {{(CNT_WIDTH-DAC_WIDTH){1'b0}}, DAC_Code};
                word_next_state = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                word_sel        = snap_pulse;
                word_next_state = ST_WR_TRIG;
            end
            default: begin
                word_sel        = snap_trig;
                word_next_state = ST_NEXT;
            end
        endcase
    end

    // The generator is launched on the CLEAR->RUN edge and halted either by
    // the counter finishing or by an abort.
    assign gen_start = (state == ST_CLEAR) && !Abort;
    assign gen_stop  = Abort || ((state == ST_RUN) && CPT_DONE);

    inject_pulse_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pulse_gen (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .Run_Start    (gen_start),
        .Run_Stop     (gen_stop),
        .Pulse_Period (period_r),
        .Pulse_High   (high_r),
        .CLK_EXT      (CLK_EXT)
    );

    // Sequencer FSM. Strobes (DAC_Load, Counter_Clr_n, Sweep_Done) default to
    // their idle level each cycle and are raised on the edge entering the
    // state that owns them, so each lasts exactly one cycle. Abort overrides
    // everything and leaves DAC_Code untouched.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            DAC_Code      <= '0;
            DAC_Load      <= 1'b0;
            Counter_Clr_n <= 1'b1;
            Test_Start    <= 1'b0;
            Data_Out      <= '0;
            Data_Valid    <= 1'b0;
            Busy          <= 1'b0;
            Sweep_Done    <= 1'b0;
            dac_stop_r    <= '0;
            dac_step_r    <= '0;
            period_r      <= '0;
            high_r        <= '0;
            settle_r      <= '0;
            settle_cnt    <= '0;
            snap_pulse    <= '0;
            snap_trig     <= '0;
        end else begin
            DAC_Load      <= 1'b0;
            Counter_Clr_n <= 1'b1;
            Sweep_Done    <= 1'b0;

            if (Abort) begin
                state      <= ST_IDLE;
                Test_Start <= 1'b0;
                Data_Valid <= 1'b0;
                Busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Start) begin
                            dac_stop_r <= (DAC_Stop < DAC_Start) ? DAC_Start : DAC_Stop;
                            dac_step_r <= (DAC_Step == '0) ? DAC_WIDTH'(1) : DAC_Step;
                            period_r   <= Pulse_Period;
                            high_r     <= Pulse_High;
                            settle_r   <= Settle_Time;
                            DAC_Code   <= DAC_Start;
                            DAC_Load   <= 1'b1;
                            Busy       <= 1'b1;
                            state      <= ST_LOAD;
                        end
                    end

                    ST_LOAD: begin
                        settle_cnt <= '0;
                        if (settle_r == '0) begin
                            Counter_Clr_n <= 1'b0;
                            state         <= ST_CLEAR;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        if (settle_cnt == settle_r - CNT_WIDTH'(1)) begin
                            Counter_Clr_n <= 1'b0;
                            state         <= ST_CLEAR;
                        end else begin
                            settle_cnt <= settle_cnt + CNT_WIDTH'(1);
                        end
                    end

                    ST_CLEAR: begin
                        Test_Start <= 1'b1;
                        state      <= ST_RUN;
                    end

                    ST_RUN: begin
                        if (CPT_DONE) begin
                            snap_pulse <= CPT_PULSE;
                            snap_trig  <= CPT_TRIGGER;
                            Test_Start <= 1'b0;
                            state      <= ST_WR_DAC;
                        end
                    end

                    // A word is loaded while Data_Valid is low and retired on
                    // the transfer edge; the next word therefore appears one
                    // cycle after each transfer.
                    ST_WR_DAC, ST_WR_PULSE, ST_WR_TRIG: begin
                        if (!Data_Valid) begin
                            Data_Out   <= word_sel;
                            Data_Valid <= 1'b1;
                        end else if (Data_Ready) begin
                            Data_Valid <= 1'b0;
                            state      <= word_next_state;
                        end
                    end

                    ST_NEXT: begin
                        if (next_code > {1'b0, dac_stop_r}) begin
                            Sweep_Done <= 1'b1;
                            state      <= ST_FINISH;
                        end else begin
                            DAC_Code <= next_code[DAC_WIDTH-1:0];
                            DAC_Load <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end

                    ST_FINISH: begin
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scurve_inject_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scurve_inject_sequencer
// Directed bench for the S-curve injection sequencer. A behavioral S-curve
// counter answers the injection clock; expected words are queued when a
// sweep is started and popped as the sink accepts them.
// ---------------------------------------------------------------------------
module tb_scurve_inject_sequencer;
    import scurve_pkg::*;

    localparam int DW      = DEFAULT_DAC_WIDTH;
    localparam int CW      = DEFAULT_CNT_WIDTH;
    localparam int CPT_MAX = 3;

    logic          Clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [DW-1:0] DAC_Start = '0;
    logic [DW-1:0] DAC_Stop = '0;
    logic [DW-1:0] DAC_Step = '0;
    logic [CW-1:0] Pulse_Period = '0;
    logic [CW-1:0] Pulse_High = '0;
    logic [CW-1:0] Settle_Time = '0;
    logic [DW-1:0] DAC_Code;
    logic          DAC_Load;
    logic          Counter_Clr_n;
    logic          Test_Start;
    logic          CLK_EXT;
    logic          CPT_DONE = 1'b0;
    logic [CW-1:0] CPT_PULSE;
    logic [CW-1:0] CPT_TRIGGER;
    logic [CW-1:0] Data_Out;
    logic          Data_Valid;
    logic          Data_Ready = 1'b1;
    logic          Busy;
    logic          Sweep_Done;

    int compared   = 0;
    int mismatched = 0;
    int sd_cnt     = 0;
    int load_cnt   = 0;
    int xfer_cnt   = 0;
    logic [CW-1:0] exp_q[$];

    scurve_inject_sequencer #(
        .DAC_WIDTH (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .Clk           (Clk),
        .reset_n       (reset_n),
        .Start         (Start),
        .Abort         (Abort),
        .DAC_Start     (DAC_Start),
        .DAC_Stop      (DAC_Stop),
        .DAC_Step      (DAC_Step),
        .Pulse_Period  (Pulse_Period),
        .Pulse_High    (Pulse_High),
        .Settle_Time   (Settle_Time),
        .DAC_Code      (DAC_Code),
        .DAC_Load      (DAC_Load),
        .Counter_Clr_n (Counter_Clr_n),
        .Test_Start    (Test_Start),
        .CLK_EXT       (CLK_EXT),
        .CPT_DONE      (CPT_DONE),
        .CPT_PULSE     (CPT_PULSE),
        .CPT_TRIGGER   (CPT_TRIGGER),
        .Data_Out      (Data_Out),
        .Data_Valid    (Data_Valid),
        .Data_Ready    (Data_Ready),
        .Busy          (Busy),
        .Sweep_Done    (Sweep_Done)
    );

    always #5 Clk = ~Clk;

    // Behavioral S-curve counter: counts CLK_EXT rising edges while enabled,
    // counts a trigger on each pulse when the threshold code is even, and
    // reports done after CPT_MAX pulses.
    logic [CW-1:0] model_pulse = '0;
    logic [CW-1:0] model_trig  = '0;
    logic          model_ext_d = 1'b0;
    logic          model_done  = 1'b0;

    always @(posedge Clk or negedge Counter_Clr_n) begin
        if (!Counter_Clr_n) begin
            model_pulse <= '0;
            model_trig  <= '0;
            model_ext_d <= 1'b0;
            model_done  <= 1'b0;
            CPT_DONE    <= 1'b0;
        end else begin
            CPT_DONE    <= 1'b0;
            model_ext_d <= CLK_EXT;
            if (Test_Start && CLK_EXT && !model_ext_d && !model_done) begin
                model_pulse <= model_pulse + CW'(1);
                if (!DAC_Code[0]) model_trig <= model_trig + CW'(1);
                if (model_pulse + CW'(1) == CW'(CPT_MAX)) begin
                    CPT_DONE   <= 1'b1;
                    model_done <= 1'b1;
                end
            end
        end
    end

    assign CPT_PULSE   = model_pulse;
    assign CPT_TRIGGER = model_trig;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sets up a sweep, queues the words it must produce and pulses Start.
    // Returns one delta after the accepting edge (the LOAD cycle).
    task automatic applyStimulus(input int s, input int e, input int st,
                                 input int per, input int hi, input int settle);
        int stop_eff;
        int step_eff;
        DAC_Start    = DW'(s);
        DAC_Stop     = DW'(e);
        DAC_Step     = DW'(st);
        Pulse_Period = CW'(per);
        Pulse_High   = CW'(hi);
        Settle_Time  = CW'(settle);
        stop_eff = (e < s) ? s : e;
        step_eff = (st == 0) ? 1 : st;
        for (int code = s; code <= stop_eff; code += step_eff) begin
            exp_q.push_back(CW'(code));
            exp_q.push_back(CW'(CPT_MAX));
            exp_q.push_back((code % 2 == 0) ? CW'(CPT_MAX) : CW'(0));
        end
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (Busy && n < 3000) begin
            @(posedge Clk); #1;
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(Busy), 0);
    endtask

    task automatic waitRun(input string tag);
        int n = 0;
        while (!Test_Start && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        checkOutput({tag, "_run"}, 32'(Test_Start), 1);
    endtask

    // Output monitor: scoreboard on transfers, hold check on stalls, event counts.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [CW-1:0] prev_out   = '0;

    always @(negedge Clk) begin
        if (reset_n) begin
            if (Sweep_Done) sd_cnt++;
            if (DAC_Load) load_cnt++;
            if (prev_valid && !prev_ready && !Abort) begin
                checkOutput("hold_valid", 32'(Data_Valid), 1);
                checkOutput("hold_data", 32'(Data_Out), 32'(prev_out));
            end
            if (Data_Valid && Data_Ready) begin
                xfer_cnt++;
                checkOutput("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) checkOutput("word", 32'(Data_Out), 32'(exp_q.pop_front()));
            end
            prev_valid = Data_Valid;
            prev_ready = Data_Ready;
            prev_out   = Data_Out;
        end
    end

    initial begin
        int clr_k;
        int ts_k;
        int sd0;
        int ld0;
        int x0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_dac_code", 32'(DAC_Code), 0);
        checkOutput("rst_dac_load", 32'(DAC_Load), 0);
        checkOutput("rst_clr_n", 32'(Counter_Clr_n), 1);
        checkOutput("rst_test_start", 32'(Test_Start), 0);
        checkOutput("rst_clk_ext", 32'(CLK_EXT), 0);
        checkOutput("rst_data_out", 32'(Data_Out), 0);
        checkOutput("rst_data_valid", 32'(Data_Valid), 0);
        checkOutput("rst_busy", 32'(Busy), 0);
        checkOutput("rst_sweep_done", 32'(Sweep_Done), 0);
        reset_n = 1'b1;
        @(posedge Clk); #1;

        // Basic sweep 100..102, step 1, period 10, high 5, settle 4
        $display("[TB] sweep 100..102");
        sd0 = sd_cnt; ld0 = load_cnt; x0 = xfer_cnt;
        applyStimulus(100, 102, 1, 10, 5, 4);
        checkOutput("t1_load_strobe", 32'(DAC_Load), 1);
        checkOutput("t1_load_code", 32'(DAC_Code), 100);
        checkOutput("t1_busy", 32'(Busy), 1);
        clr_k = 0; ts_k = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk); #1;
            if (!Counter_Clr_n && clr_k == 0) clr_k = k;
            if (Test_Start && ts_k == 0) ts_k = k;
        end
        checkOutput("t1_clear_cycle", 32'(clr_k), 5);
        checkOutput("t1_run_cycle", 32'(ts_k), 6);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin @(posedge Clk); #1; end
            checkOutput("t1_clk_ext_shape", 32'(CLK_EXT), ((i % 10) < 5) ? 1 : 0);
        end
        waitIdle("t1");
        checkOutput("t1_sweep_done_once", 32'(sd_cnt - sd0), 1);
        checkOutput("t1_loads", 32'(load_cnt - ld0), 3);
        checkOutput("t1_words", 32'(xfer_cnt - x0), 3 * WORDS_PER_POINT);
        checkOutput("t1_queue_empty", 32'(exp_q.size()), 0);
        checkOutput("t1_sweep_done_low", 32'(Sweep_Done), 0);

        // Reversed range gives a single point at DAC_Start
        $display("[TB] reversed range 8..5");
        sd0 = sd_cnt; ld0 = load_cnt; x0 = xfer_cnt;
        applyStimulus(8, 5, 1, 6, 2, 1);
        waitIdle("t2");
        checkOutput("t2_loads", 32'(load_cnt - ld0), 1);
        checkOutput("t2_words", 32'(xfer_cnt - x0), WORDS_PER_POINT);
        checkOutput("t2_sweep_done", 32'(sd_cnt - sd0), 1);
        checkOutput("t2_queue_empty", 32'(exp_q.size()), 0);

        // Top of range: 1020 + 4 must not wrap
        $display("[TB] top of range 1020..1023 step 4");
        ld0 = load_cnt; x0 = xfer_cnt;
        applyStimulus(1020, 1023, 4, 4, 1, 0);
        waitIdle("t3");
        checkOutput("t3_loads", 32'(load_cnt - ld0), 1);
        checkOutput("t3_words", 32'(xfer_cnt - x0), WORDS_PER_POINT);
        checkOutput("t3_code_held", 32'(DAC_Code), 1020);
        checkOutput("t3_queue_empty", 32'(exp_q.size()), 0);

        // Pulse_High 0, Period 1 clamps to high 1 / low 1
        $display("[TB] clamped pulse shape");
        applyStimulus(10, 10, 1, 1, 0, 2);
        waitRun("t4");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge Clk); #1; end
            checkOutput("t4_clk_ext_shape", 32'(CLK_EXT), (i % 2 == 0) ? 1 : 0);
        end
        waitIdle("t4");
        checkOutput("t4_queue_empty", 32'(exp_q.size()), 0);

        // Sink stall for 20 cycles while the pulse word is pending
        $display("[TB] sink stall");
        x0 = xfer_cnt;
        applyStimulus(20, 20, 1, 5, 2, 1);
        for (int n = 0; n < 300 && xfer_cnt == x0; n++) begin
            @(posedge Clk); #1;
        end
        checkOutput("t5_first_word", 32'(xfer_cnt - x0), 1);
        Data_Ready = 1'b0;
        repeat (20) begin @(posedge Clk); #1; end
        checkOutput("t5_stall_valid", 32'(Data_Valid), 1);
        checkOutput("t5_stall_data", 32'(Data_Out), CPT_MAX);
        checkOutput("t5_stall_no_xfer", 32'(xfer_cnt - x0), 1);
        Data_Ready = 1'b1;
        waitIdle("t5");
        checkOutput("t5_words", 32'(xfer_cnt - x0), WORDS_PER_POINT);
        checkOutput("t5_queue_empty", 32'(exp_q.size()), 0);

        // Abort two cycles into RUN
        $display("[TB] abort in RUN");
        sd0 = sd_cnt; x0 = xfer_cnt;
        applyStimulus(30, 32, 1, 10, 5, 4);
        waitRun("t6");
        repeat (2) begin @(posedge Clk); #1; end
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        checkOutput("t6_clk_ext", 32'(CLK_EXT), 0);
        checkOutput("t6_test_start", 32'(Test_Start), 0);
        checkOutput("t6_busy", 32'(Busy), 0);
        checkOutput("t6_valid", 32'(Data_Valid), 0);
        repeat (30) begin @(posedge Clk); #1; end
        checkOutput("t6_no_sweep_done", 32'(sd_cnt - sd0), 0);
        checkOutput("t6_no_words", 32'(xfer_cnt - x0), 0);
        checkOutput("t6_code_held", 32'(DAC_Code), 30);
        checkOutput("t6_busy_stays_low", 32'(Busy), 0);
        exp_q.delete();

        // Clean sweep after abort
        $display("[TB] sweep after abort");
        sd0 = sd_cnt; x0 = xfer_cnt;
        applyStimulus(40, 41, 1, 8, 3, 2);
        waitIdle("t7");
        checkOutput("t7_words", 32'(xfer_cnt - x0), 2 * WORDS_PER_POINT);
        checkOutput("t7_sweep_done", 32'(sd_cnt - sd0), 1);
        checkOutput("t7_queue_empty", 32'(exp_q.size()), 0);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
